uart_mem_bridge: RTL and testbench

- Debug/loader bridge that turns a byte stream from the UART receiver into 32-bit memory bus transactions. It returns the results as a byte stream to the UART transmitter.
- It is the initiator side of the same req/we/be/addr/wdata/rvalid/err/rdata bus that the RAM and hwreg responders serve.
- It sits between uart_rx / uart_tx instances and the memory bus mux in the demo top. Host tooling uses it to load and inspect RAM without the vector core running.

---
 rtl/uart_mem_bridge_pkg.sv | 16 +
 rtl/uart_mem_bridge.sv | 136 +++++++++++++
 tb/tb_uart_mem_bridge.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_bridge_pkg.sv
// uart_mem_bridge_pkg: shared FSM states and protocol bytes for the UART-to-memory-bus bridge
package uart_mem_bridge_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_REQ,
    S_WAIT,
    S_RESP_STAT,
    S_RESP_DATA
  } state_e;
  localparam logic [7:0] RSP_OK        = 8'h4B;
  localparam logic [7:0] RSP_ERR       = 8'h45;
  localparam logic [7:0] CMD_READ_DEF  = 8'h52;
  localparam logic [7:0] CMD_WRITE_DEF = 8'h57;
endpackage

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: turns UART command frames into 32-bit bus reads/writes and streams back status and read data
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT  = 255,
  parameter int unsigned FRAME_TIMEOUT = 1000000,
  parameter logic [7:0]  CMD_READ      = CMD_READ_DEF,
  parameter logic [7:0]  CMD_WRITE     = CMD_WRITE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic        mem_err_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);
  localparam int FW = $clog2(FRAME_TIMEOUT + 1);
  localparam int RW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [FW-1:0] FT = FW'(FRAME_TIMEOUT);
  localparam logic [RW-1:0] RT = RW'(RESP_TIMEOUT);
  state_e state_q, state_d;
  logic op_write_q, op_write_d;
  logic ok_q, ok_d;
  logic [1:0] idx_q, idx_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [RW-1:0] resp_cnt_q, resp_cnt_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_write_q  <= 1'b0;
      ok_q        <= 1'b0;
      idx_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      frame_cnt_q <= '0;
      resp_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_write_q  <= op_write_d;
      ok_q        <= ok_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      frame_cnt_q <= frame_cnt_d;
      resp_cnt_q  <= resp_cnt_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    op_write_d  = op_write_q;
    ok_d        = ok_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    frame_cnt_d = '0;
    resp_cnt_d  = '0;
    case (state_q)
      S_IDLE:
        if (rx_valid_i && (rx_data_i == CMD_READ || rx_data_i == CMD_WRITE)) begin
          op_write_d = rx_data_i == CMD_WRITE;
          idx_d      = '0;
          state_d    = S_ADDR;
        end
      S_ADDR, S_DATA:
        if (rx_valid_i) begin
          if (state_q == S_ADDR) addr_d[8*idx_q +: 8] = rx_data_i;
          else wdata_d[8*idx_q +: 8] = rx_data_i;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = (state_q == S_ADDR && op_write_q) ? S_DATA : S_REQ;
        end else if (frame_cnt_q == FT) begin
          state_d = S_IDLE;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      S_REQ: state_d = S_WAIT;
      S_WAIT:
        if (mem_rvalid_i) begin
          ok_d    = !mem_err_i;
          rdata_d = (!mem_err_i && !op_write_q) ? mem_rdata_i : rdata_q;
          state_d = S_RESP_STAT;
        end else if (resp_cnt_q == RT) begin
          ok_d    = 1'b0;
          state_d = S_RESP_STAT;
        end else begin
          resp_cnt_d = resp_cnt_q + 1'b1;
        end
      S_RESP_STAT:
        if (tx_ready_i) begin
          idx_d   = '0;
          state_d = (ok_q && !op_write_q) ? S_RESP_DATA : S_IDLE;
        end
      S_RESP_DATA:
        if (tx_ready_i) begin
          idx_d   = idx_q + 2'd1;
          state_d = idx_q == 2'd3 ? S_IDLE : S_RESP_DATA;
        end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_REQ && state_q != S_REQ) begin
      mem_addr_d  = {addr_d[31:2], 2'b00};
      mem_wdata_d = wdata_d;
    end
  end
  always_comb begin
    busy_o      = state_q != S_IDLE;
    mem_req_o   = state_q == S_REQ;
    mem_we_o    = state_q == S_REQ && op_write_q;
    mem_be_o    = state_q == S_REQ ? 4'hF : 4'h0;
    mem_addr_o  = mem_addr_q;
    mem_wdata_o = mem_wdata_q;
    tx_valid_o  = state_q == S_RESP_STAT || state_q == S_RESP_DATA;
    tx_data_o   = state_q == S_RESP_STAT ? (ok_q ? RSP_OK : RSP_ERR) :
                  state_q == S_RESP_DATA ? rdata_q[8*idx_q +: 8] : 8'h00;
  end
endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb_uart_mem_bridge: scoreboard bench driving UART frames against a bus responder model
module tb_uart_mem_bridge;
  localparam int RT = 255;
  localparam int FT = 200;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i = 1'b1;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i = 1'b0;
  logic        mem_err_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        busy_o;
  uart_mem_bridge #(.RESP_TIMEOUT(RT), .FRAME_TIMEOUT(FT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int req_cyc = 0;
  int tx_cyc = 0;
  int mode = 0;
  bit kick = 0;
  bit bp = 0;
  req_t exp_req_q[$];
  logic [7:0] exp_tx_q[$];
  logic [31:0] ram [logic [31:0]];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  initial begin
    bit pend = 0;
    logic [31:0] p_addr = 0, p_wdata = 0;
    logic p_we = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_rvalid_i = 1'b0;
      mem_err_i = 1'b0;
      if (kick) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'h5A5A5A5A;
        kick = 0;
      end else if (pend) begin
        pend = 0;
        if (mode == 0) begin
          mem_rvalid_i = 1'b1;
          if (p_we) ram[p_addr] = p_wdata;
          else mem_rdata_i = ram.exists(p_addr) ? ram[p_addr] : 32'h0;
        end else if (mode == 1) begin
          mem_rvalid_i = 1'b1;
          mem_err_i = 1'b1;
          mem_rdata_i = 32'hBAD0BAD0;
        end
      end
      if (mem_req_o) begin
        pend = 1;
        p_addr = mem_addr_o;
        p_we = mem_we_o;
        p_wdata = mem_wdata_o;
      end
    end
  end
  initial begin
    int bp_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!bp) tx_ready_i = 1'b1;
      else if (tx_ready_i || !tx_valid_o) begin
        bp_cnt = 0;
        tx_ready_i = 1'b0;
      end else begin
        bp_cnt++;
        tx_ready_i = bp_cnt >= 50;
      end
    end
  end
  logic tx_hold = 1'b0, tx_valid_prev = 1'b0;
  logic [7:0] tx_prev = 8'h00;
  always @(negedge clk) begin
    req_t er;
    if (!rst_n) begin
      tx_hold = 1'b0;
      tx_valid_prev = 1'b0;
    end else begin
      if (mem_req_o) begin
        req_cyc = cyc;
        check("req_expected", 32'(exp_req_q.size() != 0), 32'd1);
        if (exp_req_q.size() != 0) begin
          er = exp_req_q.pop_front();
          check("req_addr", mem_addr_o, er.addr);
          check("req_we", 32'(mem_we_o), 32'(er.we));
          check("req_be", 32'(mem_be_o), 32'hF);
          if (er.we) check("req_wdata", mem_wdata_o, er.wdata);
        end
      end
      if (tx_valid_o && tx_hold) check("tx_stable", 32'(tx_data_o), 32'(tx_prev));
      if (tx_valid_o && !tx_valid_prev) tx_cyc = cyc;
      if (tx_valid_o && tx_ready_i) begin
        check("tx_expected", 32'(exp_tx_q.size() != 0), 32'd1);
        if (exp_tx_q.size() != 0) check("tx_byte", 32'(tx_data_o), 32'(exp_tx_q.pop_front()));
      end
      tx_hold = tx_valid_o && !tx_ready_i;
      tx_prev = tx_data_o;
      tx_valid_prev = tx_valid_o;
    end
  end
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid_i = 1'b1;
    rx_data_i = b;
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    exp_req_q.push_back('{{a[31:2], 2'b00}, 1'b1, d});
    exp_tx_q.push_back(8'h4B);
    send_byte(8'h57);
    send_word(a);
    send_word(d);
  endtask
  task automatic do_read(input logic [31:0] a, input bit ok, input logic [31:0] d);
    exp_req_q.push_back('{{a[31:2], 2'b00}, 1'b0, 32'h0});
    exp_tx_q.push_back(ok ? 8'h4B : 8'h45);
    if (ok) for (int i = 0; i < 4; i++) exp_tx_q.push_back(d[8*i +: 8]);
    send_byte(8'h52);
    send_word(a);
  endtask
  task automatic wait_idle(string tag, int budget);
    int n = 0;
    while ((busy_o || exp_tx_q.size() != 0 || exp_req_q.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 32'({busy_o, exp_tx_q.size() != 0, exp_req_q.size() != 0}), 32'd0);
  endtask
  task automatic check_quiet(string tag);
    check(tag, {busy_o, tx_valid_o, mem_req_o, mem_we_o, mem_be_o, tx_data_o, 16'h0}, 32'h0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset_ctrl");
    check("reset_addr", mem_addr_o, 32'h0);
    check("reset_wdata", mem_wdata_o, 32'h0);
    #2;
    rst_n = 1'b1;
    do_write(32'h10, 32'hDEADBEEF);
    wait_idle("write_done", 200);
    do_read(32'h10, 1, 32'hDEADBEEF);
    wait_idle("read_done", 200);
    mode = 1;
    do_read(32'h80000000, 0, 32'h0);
    wait_idle("buserr_done", 200);
    check("buserr_busy", 32'(busy_o), 32'd0);
    mode = 2;
    do_read(32'h20, 0, 32'h0);
    wait_idle("timeout_done", RT + 50);
    check("timeout_lat", 32'(tx_cyc - req_cyc), 32'(RT + 2));
    mode = 0;
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'h00);
    repeat (FT) @(posedge clk);
    #1;
    check("frame_busy_before", 32'(busy_o), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("frame_busy_after", 32'(busy_o), 32'd0);
    do_read(32'h10, 1, 32'hDEADBEEF);
    wait_idle("after_abort", 200);
    send_byte(8'h00);
    check("garbage_00", 32'(busy_o), 32'd0);
    send_byte(8'hFF);
    check("garbage_ff", 32'(busy_o), 32'd0);
    send_byte(8'h41);
    check("garbage_41", 32'(busy_o), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check_quiet("garbage_idle");
    bp = 1;
    do_read(32'h10, 1, 32'hDEADBEEF);
    wait_idle("bp_done", 600);
    bp = 0;
    mode = 2;
    exp_req_q.push_back('{32'h10, 1'b0, 32'h0});
    send_byte(8'h52);
    send_word(32'h10);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_quiet("rst_ctrl");
    check("rst_addr", mem_addr_o, 32'h0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    kick = 1;
    repeat (20) @(posedge clk);
    #1;
    check_quiet("rst_late_rvalid");
    mode = 0;
    do_read(32'h13, 1, 32'hDEADBEEF);
    wait_idle("unaligned_done", 200);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
